// File: rtl/dac_spi_timing_pkg.sv
// dac_pkg: state encoding and frame constants shared by the DAC SPI timing block
package dac_pkg;
  localparam int FRAME_BITS = 16;
  localparam int CNT_W = 5;
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, HOLD, WAIT_LDAC, GAP} state_t;
endpackage

// File: rtl/dac_spi_timing_if.sv
// dac_spi_timing_if: run/request/ldac inputs and frame-timing outputs of the DAC SPI timing block
interface dac_spi_timing_if;
  import dac_pkg::*;
  logic key_state, start, ldac, en_dac, cs, sck, busy, frame_done, ldac_err;
  logic [CNT_W-1:0] cnt_sck;
  modport master (output key_state, start, ldac, input en_dac, cs, sck, cnt_sck, busy, frame_done, ldac_err);
  modport slave (input key_state, start, ldac, output en_dac, cs, sck, cnt_sck, busy, frame_done, ldac_err);
endinterface

// File: rtl/dac_spi_timing_sck_divider.sv
// sck_divider: half-period counter generating sck, with a strobe on the cycle before each fall
module sck_divider #(
  parameter int SCK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic fall
);
  localparam int HW = $clog2(SCK_DIV);
  logic [HW-1:0] hc;
  logic tick;
  assign tick = hc == HW'(SCK_DIV - 1);
  // fall is combinational so the bit counter updates on the same edge sck drops
  assign fall = en && tick && sck;
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      hc <= '0;
      sck <= 1'b0;
    end else begin
      hc <= tick ? '0 : hc + 1'b1;
      sck <= tick ? ~sck : sck;
    end
  end
endmodule

// File: rtl/dac_spi_timing.sv
// dac_spi_timing: per-request SPI frame timing (load strobe, cs window, sck burst, ldac handshake)
module dac_spi_timing
  import dac_pkg::*;
#(
  parameter int SCK_DIV = 2,
  parameter int FRAME_BITS = dac_pkg::FRAME_BITS,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD = 2,
  parameter int GAP_CYC = 4,
  parameter int LDAC_TIMEOUT = 32
) (
  input logic clk,
  input logic rst,
  dac_spi_timing_if.slave bus
);
  localparam int TW = $clog2(CS_SETUP + CS_HOLD + GAP_CYC + LDAC_TIMEOUT + 1);
  state_t state;
  logic pending, seen_low, fall, sck_en, sck, en_dac, cs, busy, frame_done, ldac_err;
  logic [CNT_W-1:0] cnt;
  logic [TW-1:0] tcnt;
  assign sck_en = bus.key_state && state == SHIFT;
  sck_divider #(.SCK_DIV(SCK_DIV)) u_div (.clk(clk), .rst(rst), .en(sck_en), .sck(sck), .fall(fall));
  assign bus.en_dac = en_dac;
  assign bus.cs = cs;
  assign bus.sck = sck;
  assign bus.cnt_sck = cnt;
  assign bus.busy = busy;
  assign bus.frame_done = frame_done;
  assign bus.ldac_err = ldac_err;
  always_ff @(posedge clk) begin
    if (rst || !bus.key_state) begin
      state <= IDLE;
      pending <= 1'b0;
      seen_low <= 1'b0;
      tcnt <= '0;
      cnt <= '0;
      en_dac <= 1'b0;
      cs <= 1'b1;
      busy <= 1'b0;
      frame_done <= 1'b0;
      ldac_err <= 1'b0;
    end else begin
      en_dac <= 1'b0;
      frame_done <= 1'b0;
      ldac_err <= 1'b0;
      if (state != IDLE && bus.start) pending <= 1'b1;
      case (state)
        IDLE: if (bus.start) begin
          state <= LOAD;
          en_dac <= 1'b1;
          busy <= 1'b1;
        end
        LOAD: begin
          state <= SETUP;
          cs <= 1'b0;
          tcnt <= '0;
        end
        SETUP: begin
          tcnt <= (tcnt == TW'(CS_SETUP - 1)) ? '0 : tcnt + 1'b1;
          if (tcnt == TW'(CS_SETUP - 1)) state <= SHIFT;
        end
        SHIFT: if (fall) begin
          cnt <= (cnt == CNT_W'(FRAME_BITS)) ? cnt : cnt + 1'b1;
          if (cnt == CNT_W'(FRAME_BITS - 1)) state <= HOLD;
        end
        HOLD: begin
          tcnt <= (tcnt == TW'(CS_HOLD - 1)) ? '0 : tcnt + 1'b1;
          if (tcnt == TW'(CS_HOLD - 1)) begin
            state <= WAIT_LDAC;
            cs <= 1'b1;
            cnt <= '0;
            seen_low <= 1'b0;
          end
        end
        WAIT_LDAC: begin
          tcnt <= tcnt + 1'b1;
          if (!bus.ldac) seen_low <= 1'b1;
          // a completed pulse wins over a timeout landing in the same cycle
          if (seen_low && bus.ldac) begin
            frame_done <= 1'b1;
            state <= GAP;
            tcnt <= '0;
          end else if (tcnt == TW'(LDAC_TIMEOUT - 1)) begin
            ldac_err <= 1'b1;
            state <= GAP;
            tcnt <= '0;
          end
        end
        GAP: begin
          tcnt <= (tcnt == TW'(GAP_CYC - 1)) ? '0 : tcnt + 1'b1;
          if (tcnt == TW'(GAP_CYC - 1)) begin
            state <= (pending || bus.start) ? LOAD : IDLE;
            en_dac <= pending || bus.start;
            busy <= pending || bus.start;
            pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
